// File: rtl/alu_dispatch_pkg.sv
// Shared types and default sizing for the ALU unit dispatcher.
package alu_dispatch_pkg;

  localparam int FUN_W_DEF   = 4;
  localparam int SEL_W_DEF   = 2;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/unit_onehot_dec.sv
// Combinational group-select to one-hot unit enable decoder.
module unit_onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_unit_dispatcher.sv
// Registered ALU command dispatcher: one command in flight, held one-hot unit enable.
// Optional EXEC watchdog built when ALU_DISPATCH_TIMEOUT_EN is defined.
module alu_unit_dispatcher
  import alu_dispatch_pkg::*;
#(
  parameter int FUN_W   = FUN_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [FUN_W-1:0]       ALU_FUN,
  input  logic                   FUN_VLD,
  output logic                   FUN_RDY,
  input  logic [(1<<SEL_W)-1:0]  UNIT_DONE,
  output logic [(1<<SEL_W)-1:0]  UNIT_EN,
  output logic [FUN_W-SEL_W-1:0] UNIT_OP,
  output logic                   BUSY,
  output logic                   OUT_VLD,
  output logic                   ERR,
  output logic [1:0]             dbg_state
);

  localparam int NUM_UNITS = 1 << SEL_W;

  state_t               state;
  logic [NUM_UNITS-1:0] dec_en;
  logic                 done_hit;

  // Handshake: a command transfers on a rising edge with FUN_VLD && FUN_RDY;
  // FUN_RDY depends only on state, and nothing is buffered while it is low.
  assign FUN_RDY   = (state == IDLE);
  assign dbg_state = state;

  // UNIT_EN is one-hot in EXEC, so masking picks out only the selected done bit.
  assign done_hit = |(UNIT_DONE & UNIT_EN);

  unit_onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel    (ALU_FUN[FUN_W-1 -: SEL_W]),
    .onehot (dec_en)
  );

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             err_q;
  assign timer_nxt = timer + 1'b1;
  assign ERR       = err_q;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      UNIT_EN <= '0;
      UNIT_OP <= '0;
      BUSY    <= 1'b0;
      OUT_VLD <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      timer   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (FUN_VLD) begin
            UNIT_OP <= ALU_FUN[FUN_W-SEL_W-1:0];
            UNIT_EN <= dec_en;
            BUSY    <= 1'b1;
            state   <= EXEC;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            timer   <= '0;
`endif
          end
        end
        EXEC: begin
          if (done_hit) begin
            UNIT_EN <= '0;
            OUT_VLD <= 1'b1;
            state   <= DONE;
          end
`ifdef ALU_DISPATCH_TIMEOUT_EN
          else if (timer_nxt == TMR_W'(TIMEOUT)) begin
            UNIT_EN <= '0;
            OUT_VLD <= 1'b1;
            err_q   <= 1'b1;
            state   <= DONE;
          end else begin
            timer <= timer_nxt;
          end
`endif
        end
        DONE: begin
          OUT_VLD <= 1'b0;
          BUSY    <= 1'b0;
          state   <= IDLE;
`ifdef ALU_DISPATCH_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: begin
          UNIT_EN <= '0;
          BUSY    <= 1'b0;
          OUT_VLD <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
